// File: rtl/conv3x3_engine.sv
// conv3x3_engine
//   Binary-input 3x3 convolution stage. One strt pulse followed by nine
//   serial pixel bits produces NUM_FILT signed sums (bias + selected weights).
//   Each sum goes through ReLU and saturation, then is streamed out one filter
//   at a time over a valid/ready handshake. Windows are counted per frame, and
//   frame_done pulses once the last window of a frame has been fully accepted.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous frame abort; weights/biases survive it
//   strt, din    window start (sampled in IDLE) and serial pixel bit
//   bsy          engine is not idle
//   wgt_we/addr/din  weight (k=0..8) and bias (k=9) write port, addr = f*10+k
//   out_vld/rdy/data/filt/last  result stream, one beat per filter
//   frame_done   one-cycle pulse after the final window of a frame
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for strt; weight writes accepted
// ACC   | nine pixel cycles, all filters accumulate in parallel
// OUT   | present acc[filt_cnt]; advance on accept, leave after last
module conv3x3_engine #(
  parameter int NUM_FILT      = 4,
  parameter int W_WIDTH       = 8,
  parameter int ACC_WIDTH     = 12,
  parameter int OUT_WIDTH     = 8,
  parameter int WIN_PER_FRAME = 676
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  input  logic                               strt,
  input  logic                               din,
  output logic                               bsy,
  input  logic                               wgt_we,
  input  logic [$clog2(NUM_FILT*10)-1:0]     wgt_addr,
  input  logic [W_WIDTH-1:0]                 wgt_din,
  output logic                               out_vld,
  input  logic                               out_rdy,
  output logic [OUT_WIDTH-1:0]               out_data,
  output logic [$clog2(NUM_FILT)-1:0]        out_filt,
  output logic                               out_last,
  output logic                               frame_done
);

  localparam int ADDR_W = $clog2(NUM_FILT*10);
  localparam int FILT_W = $clog2(NUM_FILT);
  localparam int WIN_W  = $clog2(WIN_PER_FRAME);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                       state, state_nxt;
  logic [3:0]                   pix_cnt;
  logic [FILT_W-1:0]            filt_cnt;
  logic [WIN_W-1:0]             win_cnt;
  logic signed [ACC_WIDTH-1:0]  acc [NUM_FILT];
  // [f][0..8] are weights, [f][9] is the bias, matching the f*10+k address map
  logic signed [W_WIDTH-1:0]    wgt [NUM_FILT][10];

  logic                         accept;
  logic                         last_filt;
  logic signed [ACC_WIDTH-1:0]  acc_sel;
  logic [OUT_WIDTH-1:0]         sat_val;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [W_WIDTH-1:0] v);
    return {{(ACC_WIDTH-W_WIDTH){v[W_WIDTH-1]}}, v};
  endfunction

  assign bsy       = (state != IDLE);
  assign last_filt = (filt_cnt == FILT_W'(NUM_FILT-1));
  assign accept    = (state == OUT) && out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (strt) state_nxt = ACC;
      ACC:  if (pix_cnt == 4'd8) state_nxt = OUT;
      OUT:  if (accept && last_filt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      pix_cnt    <= '0;
      filt_cnt   <= '0;
      win_cnt    <= '0;
      frame_done <= 1'b0;
      for (int f = 0; f < NUM_FILT; f++) acc[f] <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (strt) begin
            pix_cnt  <= '0;
            filt_cnt <= '0;
            for (int f = 0; f < NUM_FILT; f++) acc[f] <= sext(wgt[f][9]);
          end
        end
        ACC: begin
          if (din) begin
            for (int f = 0; f < NUM_FILT; f++)
              acc[f] <= acc[f] + sext(wgt[f][pix_cnt]);
          end
          pix_cnt <= (pix_cnt == 4'd8) ? 4'd0 : pix_cnt + 4'd1;
        end
        OUT: begin
          if (accept) begin
            if (last_filt) begin
              filt_cnt <= '0;
              if (win_cnt == WIN_W'(WIN_PER_FRAME-1)) begin
                win_cnt    <= '0;
                frame_done <= 1'b1;
              end else begin
                win_cnt <= win_cnt + 1'b1;
              end
            end else begin
              filt_cnt <= filt_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Address decode by comparison against every legal address: out-of-range
  // addresses simply match nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FILT; f++)
        for (int k = 0; k < 10; k++) wgt[f][k] <= '0;
    end else if (wgt_we && !bsy && !clr) begin
      for (int f = 0; f < NUM_FILT; f++)
        for (int k = 0; k < 10; k++)
          if (wgt_addr == ADDR_W'(f*10+k)) wgt[f][k] <= wgt_din;
    end
  end

  // Accumulator stays put while stalled in OUT, so data is stable without
  // a separate output register.
  always_comb begin
    acc_sel = acc[filt_cnt];
    if (acc_sel[ACC_WIDTH-1])
      sat_val = '0;
    else if (|acc_sel[ACC_WIDTH-2:OUT_WIDTH])
      sat_val = '1;
    else
      sat_val = acc_sel[OUT_WIDTH-1:0];
  end

  assign out_vld  = (state == OUT);
  assign out_data = out_vld ? sat_val : '0;
  assign out_filt = filt_cnt;
  assign out_last = out_vld && last_filt;

endmodule

// File: tb/tb_conv3x3_engine.sv
module tb_conv3x3_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       strt = 1'b0;
  logic       din = 1'b0;
  logic       bsy;
  logic       wgt_we = 1'b0;
  logic [5:0] wgt_addr = '0;
  logic [7:0] wgt_din = '0;
  logic       out_vld;
  logic       out_rdy = 1'b1;
  logic [7:0] out_data;
  logic [1:0] out_filt;
  logic       out_last;
  logic       frame_done;

  int checks = 0;
  int failures = 0;

  conv3x3_engine dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .strt(strt), .din(din), .bsy(bsy),
    .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_din(wgt_din),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_filt(out_filt), .out_last(out_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic write_wgt(input int addr, input int val);
    wgt_we   = 1'b1;
    wgt_addr = 6'(addr);
    wgt_din  = 8'(val);
    @(negedge clk);
    wgt_we   = 1'b0;
  endtask

  // all weights = w, all biases = b
  task automatic load_uniform(input int w, input int b);
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 10; k++) write_wgt(f*10+k, (k == 9) ? b : w);
  endtask

  // f0: w=-5 b=3 | f1: w=127 b=127 | f2: w=0 b=-128 | f3: w=k+1 b=20
  task automatic load_pattern();
    for (int k = 0; k < 10; k++) begin
      write_wgt(k,      (k == 9) ? 3 : -5);
      write_wgt(10 + k, 127);
      write_wgt(20 + k, (k == 9) ? -128 : 0);
      write_wgt(30 + k, (k == 9) ? 20 : k + 1);
    end
  endtask

  // Called at a negedge; returns at the negedge where the first result is due.
  task automatic start_window(input string nm, input logic [8:0] pix);
    strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    din  = pix[0];
    for (int k = 1; k < 9; k++) begin
      @(negedge clk);
      if (k == 8) check_val({nm, "_vld_early"}, int'(out_vld), 0);
      din = pix[k];
    end
    @(negedge clk);
    din = 1'b0;
    check_val({nm, "_vld_lat"}, int'(out_vld), 1);
  endtask

  task automatic collect(input string nm, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    int cyc;
    e = '{e0, e1, e2, e3};
    for (int f = 0; f < 4; f++) begin
      cyc = 0;
      while (!out_vld && cyc < 30) begin
        @(negedge clk);
        cyc++;
      end
      check_val($sformatf("%s_vld%0d", nm, f), int'(out_vld), 1);
      check_val($sformatf("%s_data%0d", nm, f), int'(out_data), e[f]);
      check_val($sformatf("%s_filt%0d", nm, f), int'(out_filt), f);
      check_val($sformatf("%s_last%0d", nm, f), int'(out_last), (f == 3) ? 1 : 0);
      @(negedge clk);
    end
    check_val({nm, "_bsy_end"}, int'(bsy), 0);
  endtask

  task automatic check_idle(input string nm);
    check_val({nm, "_bsy"}, int'(bsy), 0);
    check_val({nm, "_vld"}, int'(out_vld), 0);
    check_val({nm, "_data"}, int'(out_data), 0);
    check_val({nm, "_filt"}, int'(out_filt), 0);
    check_val({nm, "_last"}, int'(out_last), 0);
    check_val({nm, "_fd"}, int'(frame_done), 0);
  endtask

  initial begin
    int acc_cnt;
    int fd_cnt;
    int cyc;

    repeat (3) @(negedge clk);
    check_idle("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // unit weights, zero bias, all pixels set -> 9 per filter
    load_uniform(1, 0);
    start_window("ones", 9'h1FF);
    collect("ones", 9, 9, 9, 9);

    load_pattern();
    start_window("winA", 9'b000010001);
    collect("winA", 0, 255, 0, 26);
    start_window("winB", 9'h1FF);
    collect("winB", 0, 255, 0, 65);
    start_window("winC", 9'h000);
    collect("winC", 3, 127, 0, 20);
    start_window("winD", 9'b100000000);
    collect("winD", 0, 254, 0, 29);

    // backpressure on filter 1; strt and a bias write attempted while busy
    start_window("stall", 9'b100000000);
    check_val("stall_f0", int'(out_data), 0);
    @(negedge clk);
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_filt", int'(out_filt), 1);
      check_val("stall_data", int'(out_data), 254);
      check_val("stall_vld", int'(out_vld), 1);
      check_val("stall_bsy", int'(bsy), 1);
      strt = (i == 1);
      if (i == 2) begin
        wgt_we = 1'b1; wgt_addr = 6'd9; wgt_din = 8'd100;
      end else begin
        wgt_we = 1'b0;
      end
    end
    strt = 1'b0;
    wgt_we = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    check_val("stall_f2_filt", int'(out_filt), 2);
    check_val("stall_f2_data", int'(out_data), 0);
    @(negedge clk);
    check_val("stall_f3_data", int'(out_data), 29);
    check_val("stall_f3_last", int'(out_last), 1);
    @(negedge clk);
    check_val("stall_bsy_fall", int'(bsy), 0);
    repeat (2) @(negedge clk);
    check_val("stall_no_restart", int'(bsy), 0);
    start_window("busywr", 9'h000);
    collect("busywr", 3, 127, 0, 20);

    // clr in the middle of accumulation
    strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    din = 1'b1;
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    din = 1'b0;
    check_idle("clr");
    start_window("postclr", 9'b100000000);
    collect("postclr", 0, 254, 0, 29);

    // two full frames back to back, strt held high throughout
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    acc_cnt = 0;
    fd_cnt = 0;
    cyc = 0;
    strt = 1'b1;
    din = 1'b1;
    while (acc_cnt < 1352 && cyc < 25000) begin
      @(negedge clk);
      cyc++;
      if (frame_done) begin
        fd_cnt++;
        check_val("fd_pos", acc_cnt, 676 * fd_cnt);
      end
      if (out_vld && out_last) acc_cnt++;
    end
    strt = 1'b0;
    din = 1'b0;
    @(negedge clk);
    if (frame_done) begin
      fd_cnt++;
      check_val("fd_pos", acc_cnt, 676 * fd_cnt);
    end
    check_val("frame_windows", acc_cnt, 1352);
    check_val("fd_count", fd_cnt, 2);
    @(negedge clk);
    check_val("fd_after", int'(frame_done), 0);

    // async reset mid-accumulation clears weights as well
    strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    din = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("arst_bsy", int'(bsy), 0);
    @(negedge clk);
    check_idle("arst");
    rst_n = 1'b1;
    din = 1'b0;
    @(negedge clk);
    start_window("postrst", 9'b100000001);
    collect("postrst", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
